// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register-file read-port arbiter.
// The optional XZR read-as-zero behaviour is controlled by the REGFILE_XZR_EN macro.
package regfile_pkg;

  // Register address width and register count of the read mux.
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Architectural zero register.
  localparam logic [REG_ADDR_W-1:0] XZR_ADDR = 5'd31;

  // True when the address names the zero register.
  function automatic logic is_xzr(input logic [REG_ADDR_W-1:0] addr);
    return (addr == XZR_ADDR);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter.
// The search starts at ptr and wraps modulo NREQ; the first asserted request wins.
// NREQ must be a power of two so the index arithmetic wraps naturally in IDW bits.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  winner,
  output logic            any_grant
);

  // Walk the requesters from ptr upward, keeping the first valid one.
  always_comb begin
    logic [IDW-1:0] idx;
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx       = '0;
    if (enable) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = ptr + IDW'(k);
        if (!any_grant && req[idx]) begin
          any_grant   = 1'b1;
          winner      = idx;
          grant[idx]  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one register-file read port among NREQ requesters.
// One requester is granted per cycle (round-robin), its address drives the read
// mux select in the same cycle, and the mux output is captured into a registered
// response tagged with the requester index.
// Optional feature: define REGFILE_XZR_EN to force reads of address 31 to zero.
//
// Handshake (both sides): a transfer happens in a cycle where valid and ready
// are both high. Requesters hold req_valid/req_addr until req_ready; the
// response holds rsp_valid/rsp_id/rsp_data stable until rsp_ready.
module regfile_port_arbiter
  import regfile_pkg::*;
#(
  parameter int N    = 64,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [REG_ADDR_W*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]            req_ready,
  output logic [REG_ADDR_W-1:0]      mux_sel,
  input  logic [N-1:0]               mux_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [N-1:0]               rsp_data
);

  logic [IDW-1:0]        ptr;
  logic [REG_ADDR_W-1:0] last_sel;
  logic                  slot_free;
  logic                  arb_en;
  logic [NREQ-1:0]       grant;
  logic [IDW-1:0]        winner;
  logic                  any_grant;
  logic [REG_ADDR_W-1:0] win_addr;
  logic [N-1:0]          cap_data;

  // A grant is possible only when the response slot is empty or draining,
  // and never while reset is held.
  assign slot_free = !rsp_valid || rsp_ready;
  assign arb_en    = slot_free && !reset;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .enable    (arb_en),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  assign req_ready = grant;

  // Pick the winner's address field and steer the mux; hold the previous
  // select when idle so the read mux does not toggle needlessly.
  always_comb begin
    win_addr = req_addr[int'(winner)*REG_ADDR_W +: REG_ADDR_W];
    mux_sel  = any_grant ? win_addr : last_sel;
  end

  // Data to capture on a grant; the zero register optionally reads as zero.
  always_comb begin
    cap_data = mux_data;
`ifdef REGFILE_XZR_EN
    if (is_xzr(win_addr)) begin
      cap_data = '0;
    end
`endif
  end

  // Response register, round-robin pointer and held select.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      ptr       <= '0;
      last_sel  <= '0;
    end else if (any_grant) begin
      rsp_valid <= 1'b1;
      rsp_data  <= cap_data;
      rsp_id    <= winner;
      ptr       <= winner + IDW'(1);
      last_sel  <= win_addr;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed testbench for regfile_port_arbiter (N=64, NREQ=4).
// The read mux is modelled as a 32-entry array indexed by mux_sel.
module tb_regfile_port_arbiter;

  localparam int N    = 64;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic            clock;
  logic            reset;
  logic [NREQ-1:0] req_valid;
  logic [5*NREQ-1:0] req_addr;
  logic [NREQ-1:0] req_ready;
  logic [4:0]      mux_sel;
  logic [N-1:0]    mux_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [N-1:0]    rsp_data;

  logic [N-1:0] regs [32];
  int tests_run;
  int tests_failed;

  assign mux_data = regs[mux_sel];

  regfile_port_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .mux_sel   (mux_sel),
    .mux_data  (mux_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  // Clock and safety timeout.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #20000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [4:0] a);
    req_addr[i*5 +: 5] = a;
  endtask

  initial begin
    logic [N-1:0] exp_xzr;
    logic [4:0]   addrs [4];
    int           w;
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 32; i++) regs[i] = {32'hA5A5_0000, 32'(i * 16 + 3)};
    regs[5]  = 64'hDEAD;
    regs[31] = {64{1'b1}};

    // Reset, with a request present to show req_ready stays low.
    reset     = 1'b1;
    req_valid = 4'b0001;
    req_addr  = '0;
    rsp_ready = 1'b1;
    #2;
    check("rst_req_ready", 64'(req_ready), 64'h0);
    tick(); tick();
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rsp_data", rsp_data, 64'h0);
    reset     = 1'b0;
    req_valid = 4'b0000;
    #1;
    check("rst_mux_sel", 64'(mux_sel), 64'h0);

    // Single request from requester 0 reading X5.
    req_valid = 4'b0001;
    set_addr(0, 5'd5);
    #1;
    check("t1_req_ready", 64'(req_ready), 64'h1);
    check("t1_mux_sel", 64'(mux_sel), 64'd5);
    tick();
    req_valid = 4'b0000;
    #1;
    check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t1_rsp_id", 64'(rsp_id), 64'h0);
    check("t1_rsp_data", rsp_data, 64'hDEAD);
    check("t1_sel_hold", 64'(mux_sel), 64'd5);
    tick();
    check("t1_retire", 64'(rsp_valid), 64'h0);

    // Idle cycles leave ptr at 1; only requester 3 valid -> wrap search.
    tick();
    req_valid = 4'b1000;
    set_addr(3, 5'd7);
    #1;
    check("wrap_req_ready", 64'(req_ready), 64'h8);
    tick();
    req_valid = 4'b0000;
    #1;
    check("wrap_rsp_id", 64'(rsp_id), 64'h3);
    check("wrap_rsp_data", rsp_data, regs[7]);

    // All four requesters continuously valid: ptr is now 0 -> 0,1,2,3,0.
    addrs[0] = 5'd1; addrs[1] = 5'd2; addrs[2] = 5'd3; addrs[3] = 5'd4;
    for (int i = 0; i < 4; i++) set_addr(i, addrs[i]);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      w = k % 4;
      #1;
      check($sformatf("rr_grant_%0d", k), 64'(req_ready), 64'(1 << w));
      check($sformatf("rr_sel_%0d", k), 64'(mux_sel), 64'(addrs[w]));
      tick();
      check($sformatf("rr_rsp_id_%0d", k), 64'(rsp_id), 64'(w));
      check($sformatf("rr_rsp_data_%0d", k), rsp_data, regs[addrs[w]]);
    end

    // Backpressure for three cycles with all still requesting; ptr is 1.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_req_ready_%0d", k), 64'(req_ready), 64'h0);
      check($sformatf("bp_rsp_valid_%0d", k), 64'(rsp_valid), 64'h1);
      check($sformatf("bp_rsp_id_%0d", k), 64'(rsp_id), 64'h0);
      check($sformatf("bp_rsp_data_%0d", k), rsp_data, regs[addrs[0]]);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_grant", 64'(req_ready), 64'h2);
    tick();
    check("bp_release_id", 64'(rsp_id), 64'h1);
    check("bp_release_data", rsp_data, regs[addrs[1]]);

    // Requester 2 reads X31 with the mux returning all ones; ptr is 2.
    req_valid = 4'b0100;
    set_addr(2, 5'd31);
    #1;
    check("xzr_sel", 64'(mux_sel), 64'd31);
    tick();
    req_valid = 4'b0000;
`ifdef REGFILE_XZR_EN
    exp_xzr = '0;
`else
    exp_xzr = {64{1'b1}};
`endif
    #1;
    check("xzr_rsp_id", 64'(rsp_id), 64'h2);
    check("xzr_rsp_data", rsp_data, exp_xzr);

    // Reset in the middle of backpressure; ptr is 3 so requester 3 wins first.
    req_valid = 4'b1001;
    set_addr(0, 5'd5);
    set_addr(3, 5'd9);
    #1;
    check("mr_pre_grant", 64'(req_ready), 64'h8);
    tick();
    rsp_ready = 1'b0;
    tick();
    check("mr_bp_valid", 64'(rsp_valid), 64'h1);
    check("mr_bp_id", 64'(rsp_id), 64'h3);
    reset = 1'b1;
    #1;
    check("mr_async_valid", 64'(rsp_valid), 64'h0);
    check("mr_async_data", rsp_data, 64'h0);
    check("mr_async_id", 64'(rsp_id), 64'h0);
    check("mr_req_ready", 64'(req_ready), 64'h0);
    reset     = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("mr_after_grant", 64'(req_ready), 64'h1);
    check("mr_after_sel", 64'(mux_sel), 64'd5);
    tick();
    req_valid = 4'b0000;
    #1;
    check("mr_after_id", 64'(rsp_id), 64'h0);
    check("mr_after_data", rsp_data, 64'hDEAD);

    // Idle cycles must not move ptr (now 1): all valid -> requester 1 first.
    tick(); tick();
    check("idle_retired", 64'(rsp_valid), 64'h0);
    req_valid = 4'b1111;
    #1;
    check("idle_ptr_hold", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'b0000;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
